// File: rtl/seq_comparator.sv
// Multi-cycle magnitude comparator: walks the operands CHUNK bits per cycle from the
// MSB end and stops at the first differing chunk, producing gt/lt/eq and CPSR flags.
module seq_comparator #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic             busy,
    output logic             done,
    output logic             gt,
    output logic             lt,
    output logic             eq,
    output logic             negative,
    output logic             zero,
    output logic             cout,
    output logic             overflow
);

    localparam int N    = WIDTH / CHUNK;
    localparam int IDXW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic [IDXW-1:0]   idx_q, idx_d;
    logic              done_q, done_d;
    logic              gt_q, gt_d;
    logic              lt_q, lt_d;
    logic              eq_q, eq_d;

    logic [WIDTH-1:0]  msb_flip;
    logic [CHUNK-1:0]  a_chunk;
    logic [CHUNK-1:0]  b_chunk;

    always_comb begin
        // Signed order is unsigned order with both sign bits inverted, so the flip
        // is folded into the latched operands and the datapath stays unsigned.
        msb_flip            = '0;
        msb_flip[WIDTH-1]   = signed_mode;

        a_chunk = CHUNK'(a_q >> (idx_q * CHUNK));
        b_chunk = CHUNK'(b_q >> (idx_q * CHUNK));

        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        idx_d   = idx_q;
        done_d  = 1'b0;
        gt_d    = gt_q;
        lt_d    = lt_q;
        eq_d    = eq_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = x ^ msb_flip;
                    b_d     = y ^ msb_flip;
                    idx_d   = IDXW'(N - 1);
                    state_d = RUN;
                end
            end
            RUN: begin
                if (a_chunk != b_chunk) begin
                    gt_d    = (a_chunk > b_chunk);
                    lt_d    = (a_chunk < b_chunk);
                    eq_d    = 1'b0;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else if (idx_q == '0) begin
                    gt_d    = 1'b0;
                    lt_d    = 1'b0;
                    eq_d    = 1'b1;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    idx_d = idx_q - IDXW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            idx_q   <= '0;
            done_q  <= 1'b0;
            gt_q    <= 1'b0;
            lt_q    <= 1'b0;
            eq_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            idx_q   <= idx_d;
            done_q  <= done_d;
            gt_q    <= gt_d;
            lt_q    <= lt_d;
            eq_q    <= eq_d;
        end
    end

    assign busy     = (state_q == RUN);
    assign done     = done_q;
    assign gt       = gt_q;
    assign lt       = lt_q;
    assign eq       = eq_q;
    assign negative = lt_q;
    assign zero     = eq_q;
    assign cout     = gt_q | eq_q;
    assign overflow = 1'b0;

endmodule

// File: tb/tb_seq_comparator.sv
// Directed plus randomized checks of seq_comparator (16/4 and single-cycle 16/16)
// against an arithmetic reference model.
module tb_seq_comparator;

    localparam int W = 16;
    localparam int C = 4;
    localparam int N = W / C;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         sm;
    logic [W-1:0] xin;
    logic [W-1:0] yin;

    logic busy, done, gt, lt, eq, negative, zero, cout, overflow;
    logic s_busy, s_done, s_gt, s_lt, s_eq, s_negative, s_zero, s_cout, s_overflow;

    int compared   = 0;
    int mismatched = 0;

    logic exp_gt, exp_lt, exp_eq;
    int   exp_k;

    seq_comparator #(.WIDTH(W), .CHUNK(C)) u_dut (
        .clk(clk), .rst(rst), .start(start), .signed_mode(sm), .x(xin), .y(yin),
        .busy(busy), .done(done), .gt(gt), .lt(lt), .eq(eq),
        .negative(negative), .zero(zero), .cout(cout), .overflow(overflow)
    );

    seq_comparator #(.WIDTH(W), .CHUNK(W)) u_single (
        .clk(clk), .rst(rst), .start(start), .signed_mode(sm), .x(xin), .y(yin),
        .busy(s_busy), .done(s_done), .gt(s_gt), .lt(s_lt), .eq(s_eq),
        .negative(s_negative), .zero(s_zero), .cout(s_cout), .overflow(s_overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Chunks inspected = distance of the highest differing bit's chunk from the top.
    function automatic int model_latency(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] d;
        d = a ^ b;
        for (int i = W - 1; i >= 0; i--)
            if (d[i]) return N - i / C;
        return N;
    endfunction

    task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        xin   = a;
        yin   = b;
        sm    = s;
        start = 1'b1;
        if (s) begin
            exp_gt = ($signed(a) > $signed(b));
            exp_lt = ($signed(a) < $signed(b));
        end else begin
            exp_gt = (a > b);
            exp_lt = (a < b);
        end
        exp_eq = (a == b);
        exp_k  = model_latency(a, b);
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic check_results(input string tag, input logic g, input logic l, input logic e,
                                 input logic n, input logic z, input logic c, input logic v);
        check({tag, ".gt"}, 32'(g), 32'(exp_gt));
        check({tag, ".lt"}, 32'(l), 32'(exp_lt));
        check({tag, ".eq"}, 32'(e), 32'(exp_eq));
        check({tag, ".N"},  32'(n), 32'(exp_lt));
        check({tag, ".Z"},  32'(z), 32'(exp_eq));
        check({tag, ".C"},  32'(c), 32'(exp_gt | exp_eq));
        check({tag, ".V"},  32'(v), 32'(0));
    endtask

    // Returns #1 after the edge on which done rose; operands are scrambled while busy.
    task automatic finish_cmp(input string tag);
        bit got;
        got = 1'b0;
        for (int c = 1; c <= N + 2 && !got; c++) begin
            @(posedge clk);
            #1;
            if (c == 1) begin
                check({tag, ".s_done"}, 32'(s_done), 32'd1);
                check_results({tag, ".s"}, s_gt, s_lt, s_eq, s_negative, s_zero, s_cout, s_overflow);
            end
            if (done) begin
                got = 1'b1;
                check({tag, ".lat"},  32'(c),    32'(exp_k));
                check({tag, ".busy"}, 32'(busy), 32'd0);
                check_results(tag, gt, lt, eq, negative, zero, cout, overflow);
            end else begin
                check({tag, ".busy_run"}, 32'(busy), 32'd1);
                xin = W'($urandom);
                yin = W'($urandom);
            end
        end
        if (!got) check({tag, ".timeout"}, 32'd0, 32'd1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".outs"},
              32'({busy, done, gt, lt, eq, negative, zero, cout, overflow}), 32'd0);
        check({tag, ".s_outs"},
              32'({s_busy, s_done, s_gt, s_lt, s_eq, s_negative, s_zero, s_cout, s_overflow}), 32'd0);
    endtask

    initial begin
        logic [W-1:0] a, b;
        logic         s;

        rst   = 1'b1;
        start = 1'b0;
        sm    = 1'b0;
        xin   = '0;
        yin   = '0;
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst = 1'b0;

        @(negedge clk); launch(16'h8000, 16'h7FFF, 1'b0); finish_cmp("u_top");
        @(negedge clk); launch(16'h8000, 16'h7FFF, 1'b1); finish_cmp("s_top");
        @(negedge clk); launch(16'hA5C3, 16'hA5C3, 1'b0); finish_cmp("u_equal");
        @(negedge clk); launch(16'h1234, 16'h1235, 1'b0); finish_cmp("u_low");
        @(negedge clk); launch(16'h1334, 16'h1234, 1'b0); finish_cmp("u_second");

        // Abort on the second RUN cycle.
        @(negedge clk); launch(16'h0001, 16'h0001, 1'b0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_all_zero("abort");
        for (int i = 0; i < N + 1; i++) begin
            @(posedge clk); #1;
            check("abort.no_done", 32'(done), 32'd0);
        end
        @(negedge clk); launch(16'h0042, 16'h0041, 1'b0); finish_cmp("after_rst");

        // Back-to-back: new start raised while done is high.
        @(negedge clk); launch(16'h0100, 16'h0100, 1'b1); finish_cmp("b2b_first");
        check("b2b.done_high", 32'(done), 32'd1);
        launch(16'hFFFF, 16'h0000, 1'b1); finish_cmp("b2b_second");

        for (int t = 0; t < 60; t++) begin
            a = W'($urandom);
            case ($urandom_range(0, 3))
                0: b = a;
                1: b = a ^ W'(16'h1 << $urandom_range(0, W - 1));
                2: b = {a[W-1:8], 8'($urandom)};
                default: b = W'($urandom);
            endcase
            s = 1'($urandom);
            @(negedge clk);
            launch(a, b, s);
            finish_cmp("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
